// File: rtl/free_list_if.sv
// Dispatch/commit-side bundle of the physical-register free list.
// The controller takes the slave modport.
interface free_list_if #(
  parameter int SS         = 2,
  parameter int PR_ENTRIES = 64,
  parameter int ARCH_REGS  = 32
);
  localparam int DEPTH = PR_ENTRIES - ARCH_REGS;
  localparam int PW    = $clog2(PR_ENTRIES);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                   alloc_req;
  logic                   alloc_ok;
  logic [SS-1:0][PW-1:0]  free_list_regs;
  logic [SS-1:0]          rel_valid;
  logic [SS-1:0][PW-1:0]  rel_pr;
  logic [CNT_W-1:0]       free_count;
  logic                   avail;
  logic                   overflow_err;

  modport master (
    output alloc_req, rel_valid, rel_pr,
    input  alloc_ok, free_list_regs, free_count, avail, overflow_err
  );

  modport slave (
    input  alloc_req, rel_valid, rel_pr,
    output alloc_ok, free_list_regs, free_count, avail, overflow_err
  );
endinterface

// File: rtl/free_list_ctrl.sv
// Circular FIFO of free physical register indices: SS-wide all-or-nothing
// allocation at the head, compacted reclaim of committed registers at the tail.
module free_list_ctrl #(
  parameter int SS         = 2,
  parameter int PR_ENTRIES = 64,
  parameter int ARCH_REGS  = 32
) (
  input logic       clk,
  input logic       rst,
  free_list_if.slave fl
);
  localparam int DEPTH = PR_ENTRIES - ARCH_REGS;
  localparam int PW    = $clog2(PR_ENTRIES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [PW-1:0]    entry_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] free_count_r;
  logic             overflow_r;

  logic             avail_s;
  logic             alloc_ok_s;
  logic [CNT_W-1:0] taken_s;
  logic [CNT_W-1:0] acc_s;
  logic [SUM_W-1:0] occ_s;
  logic             drop_s;
  logic [SS-1:0]    wr_en_s;
  logic [PTR_W-1:0] wr_ptr_s [SS];

  // Explicit modulo-DEPTH add so non-power-of-two depths wrap correctly.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [CNT_W-1:0] inc);
    logic [PTR_W:0] s;
    s = {1'b0, p} + inc;
    s = (s >= (PTR_W+1)'(DEPTH)) ? (s - (PTR_W+1)'(DEPTH)) : s;
    return s[PTR_W-1:0];
  endfunction

  assign avail_s    = (free_count_r >= CNT_W'(SS));
  assign alloc_ok_s = fl.alloc_req & avail_s;

  // Compact valid non-p0 releases and accept them while the list has room after this cycle's grant.
  always_comb begin
    taken_s = alloc_ok_s ? CNT_W'(SS) : '0;
    acc_s   = '0;
    occ_s   = '0;
    drop_s  = 1'b0;
    wr_en_s = '0;
    for (int j = 0; j < SS; j++) begin
      wr_ptr_s[j] = ptr_add(tail_r, acc_s);
      occ_s = SUM_W'(free_count_r) - SUM_W'(taken_s) + SUM_W'(acc_s);
      if (fl.rel_valid[j] && (fl.rel_pr[j] != '0)) begin
        if (occ_s < SUM_W'(DEPTH)) begin
          wr_en_s[j] = 1'b1;
          acc_s      = acc_s + CNT_W'(1);
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        wr_en_s[j] = 1'b0;
      end
    end
  end

  // Head, tail, credit count and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r       <= '0;
      tail_r       <= '0;
      free_count_r <= CNT_W'(DEPTH);
      overflow_r   <= 1'b0;
    end else begin
      head_r       <= alloc_ok_s ? ptr_add(head_r, CNT_W'(SS)) : head_r;
      tail_r       <= ptr_add(tail_r, acc_s);
      free_count_r <= free_count_r - taken_s + acc_s;
      overflow_r   <= overflow_r | drop_s;
    end
  end

  // FIFO storage: at reset the list holds every register not mapped to an architectural one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= PW'(ARCH_REGS + i);
      end
    end else begin
      for (int j = 0; j < SS; j++) begin
        if (wr_en_s[j]) begin
          entry_r[wr_ptr_s[j]] <= fl.rel_pr[j];
        end
      end
    end
  end

  for (genvar k = 0; k < SS; k++) begin : g_out
    assign fl.free_list_regs[k] = entry_r[ptr_add(head_r, CNT_W'(k))];
  end

  assign fl.alloc_ok     = alloc_ok_s;
  assign fl.free_count   = free_count_r;
  assign fl.avail        = avail_s;
  assign fl.overflow_err = overflow_r;
endmodule
